// File: rtl/calc_entry_fsm_if.sv
// Keypad event bus between keypadController (master) and calc_entry_fsm (slave).
// key_pushed stays high while a key is held; data_in/key_type describe that key.
interface calc_entry_fsm_if;
    logic       key_pushed;
    logic [3:0] data_in;
    logic [1:0] key_type;

    modport master (output key_pushed, output data_in, output key_type);
    modport slave  (input  key_pushed, input  data_in, input  key_type);
endinterface

// File: rtl/calc_entry_fsm.sv
// Calculator entry FSM: builds decimal operands from key events, latches an operator
// and evaluates on equals or on operator chaining, driving a registered signed display.
module calc_entry_fsm #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic                    clk_slow,
    input  logic                    rst_n,
    calc_entry_fsm_if.slave         kp,
    output logic signed [WIDTH-1:0] display,
    output logic [1:0]              op_code,
    output logic [1:0]              state,
    output logic                    result_valid,
    output logic                    overflow
);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam logic signed [WIDTH-1:0] TEN = WIDTH'(10);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t                    state_r;
    logic                      kp_q_r;
    logic signed [WIDTH-1:0]   acc_a_r;
    logic signed [WIDTH-1:0]   acc_b_r;
    logic [DW-1:0]             digits_r;

    logic                      event_s;
    logic                      digit_ok_s;
    logic                      digit_room_s;
    logic signed [WIDTH-1:0]   d_ext_s;
    logic signed [WIDTH-1:0]   entry_src_s;
    logic signed [WIDTH-1:0]   entry_next_s;
    logic                      op_valid_s;
    logic [1:0]                new_op_s;
    logic signed [2*WIDTH-1:0] a_w_s;
    logic signed [2*WIDTH-1:0] b_w_s;
    logic signed [2*WIDTH-1:0] alu_full_s;
    logic [WIDTH:0]            alu_upper_s;
    logic signed [WIDTH-1:0]   alu_res_s;
    logic                      alu_ovf_s;

    assign state        = state_r;
    assign event_s      = kp.key_pushed & ~kp_q_r;
    assign digit_ok_s   = (kp.data_in <= 4'd9);
    assign digit_room_s = (digits_r < DW'(MAX_DIGITS));
    assign d_ext_s      = {{(WIDTH-4){1'b0}}, kp.data_in};
    assign entry_src_s  = (state_r == ENTER_B) ? acc_b_r : acc_a_r;
    assign entry_next_s = entry_src_s * TEN + d_ext_s;

    // Operator key decode: only A/B/C are operators, everything else is ignored
    always_comb begin
        new_op_s   = 2'd0;
        op_valid_s = 1'b0;
        case (kp.data_in)
            4'hA:    begin new_op_s = 2'd1; op_valid_s = 1'b1; end
            4'hB:    begin new_op_s = 2'd2; op_valid_s = 1'b1; end
            4'hC:    begin new_op_s = 2'd3; op_valid_s = 1'b1; end
            default: begin new_op_s = 2'd0; op_valid_s = 1'b0; end
        endcase
    end

    // Double-width evaluation of acc_a op acc_b; the product of two WIDTH values fits exactly
    always_comb begin
        a_w_s = {{WIDTH{acc_a_r[WIDTH-1]}}, acc_a_r};
        b_w_s = {{WIDTH{acc_b_r[WIDTH-1]}}, acc_b_r};
        case (op_code)
            2'd1:    alu_full_s = a_w_s + b_w_s;
            2'd2:    alu_full_s = a_w_s - b_w_s;
            2'd3:    alu_full_s = a_w_s * b_w_s;
            default: alu_full_s = a_w_s;
        endcase
    end

    // Result fits only when every bit above the WIDTH sign bit equals that sign bit
    assign alu_upper_s = alu_full_s[2*WIDTH-1:WIDTH-1];
    assign alu_res_s   = alu_full_s[WIDTH-1:0];
    assign alu_ovf_s   = ~((&alu_upper_s) | ~(|alu_upper_s));

    // Entry FSM; display is updated in the same edge as the register it mirrors
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            kp_q_r       <= 1'b0;
            state_r      <= ENTER_A;
            acc_a_r      <= '0;
            acc_b_r      <= '0;
            digits_r     <= '0;
            op_code      <= 2'd0;
            display      <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            kp_q_r       <= kp.key_pushed;
            result_valid <= 1'b0;
            if (event_s) begin
                case (kp.key_type)
                    2'd0: begin
                        if (digit_ok_s && (state_r == RESULT)) begin
                            acc_a_r  <= d_ext_s;
                            digits_r <= DW'(1);
                            op_code  <= 2'd0;
                            overflow <= 1'b0;
                            state_r  <= ENTER_A;
                            display  <= d_ext_s;
                        end else if (digit_ok_s && digit_room_s) begin
                            digits_r <= digits_r + DW'(1);
                            display  <= entry_next_s;
                            if (state_r == ENTER_B) begin
                                acc_b_r <= entry_next_s;
                            end else begin
                                acc_a_r <= entry_next_s;
                            end
                        end
                    end
                    2'd1: begin
                        if (op_valid_s) begin
                            case (state_r)
                                ENTER_A, RESULT: begin
                                    op_code  <= new_op_s;
                                    acc_b_r  <= '0;
                                    digits_r <= '0;
                                    state_r  <= ENTER_B;
                                    display  <= acc_a_r;
                                end
                                ENTER_B: begin
                                    op_code <= new_op_s;
                                    if (digits_r != '0) begin
                                        acc_a_r      <= alu_res_s;
                                        overflow     <= overflow | alu_ovf_s;
                                        result_valid <= 1'b1;
                                        acc_b_r      <= '0;
                                        digits_r     <= '0;
                                        display      <= alu_res_s;
                                    end
                                end
                                default: state_r <= ENTER_A;
                            endcase
                        end
                    end
                    2'd2: begin
                        case (state_r)
                            ENTER_B: begin
                                acc_a_r      <= alu_res_s;
                                overflow     <= overflow | alu_ovf_s;
                                result_valid <= 1'b1;
                                state_r      <= RESULT;
                                display      <= alu_res_s;
                            end
                            ENTER_A: begin
                                result_valid <= 1'b1;
                                state_r      <= RESULT;
                                display      <= acc_a_r;
                            end
                            RESULT:  state_r <= RESULT;
                            default: state_r <= ENTER_A;
                        endcase
                    end
                    default: begin
                        // Clear: kp_q keeps tracking the pad so a held clear key acts once
                        state_r  <= ENTER_A;
                        acc_a_r  <= '0;
                        acc_b_r  <= '0;
                        digits_r <= '0;
                        op_code  <= 2'd0;
                        display  <= '0;
                        overflow <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/calc_entry_fsm.md
# calc_entry_fsm

Consumes the key events produced by `keypadController` (`key_pushed`, `data_in`, `key_type`) and turns them into calculator operations. It assembles decimal operands digit by digit, latches an operator, and evaluates on equals. It drives the signed value to be shown on the display. It is the downstream end of the keypad interface, sitting between `keypadController` and the display driver.

## Interface
- `WIDTH`, default 16: signed operand and result width in bits.
- `MAX_DIGITS`, default 4: maximum decimal digits accepted per operand.
- `clk_slow`  in  1  system clock, the same clock as `keypadController`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_pushed`  in  1  high for as long as a key is held.
- `data_in`  in  4  key code; only meaningful while `key_pushed`=1.
- `key_type`  in  2  key class: 0=digit, 1=operator, 2=equals, 3=clear.
- `display`  out  WIDTH  signed value currently shown.
- `op_code`  out  2  latched operator: 0=none, 1=add, 2=sub, 3=mul.
- `state`  out  2  FSM state: 0=ENTER_A, 1=ENTER_B, 2=RESULT.
- `result_valid`  out  1  one-cycle pulse when a result is computed.
- `overflow`  out  1  sticky flag: the last computed result did not fit in WIDTH.

## Operation
- **Edge detect:** register `kp_q` <= `key_pushed`. A key event occurs on a clock edge where `key_pushed`=1 and `kp_q`=0. Holding a key produces exactly one event. `data_in` and `key_type` are sampled on that same edge.
- **Registers:**
  - `acc_a` and `acc_b` (signed WIDTH).
  - `op_code`.
  - `digits` (count of digits in the current operand).
  - `state`.
- **Operator decode** (`key_type`=1): `data_in` 4'hA=add, 4'hB=sub, 4'hC=mul. Any other code is ignored.
- **Digit** (`key_type`=0, `data_in` 0..9):
  - ENTER_A: `acc_a` = `acc_a`*10 + d.
  - ENTER_B: `acc_b` = `acc_b`*10 + d.
  - Ignored if `digits`=MAX_DIGITS or `data_in`>9.
  - In RESULT: `acc_a` = d, `digits`=1, `op_code`=0, `overflow`=0, state -> ENTER_A.
- **Operator:**
  - In ENTER_A: latch `op_code`, `acc_b`=0, `digits`=0, state -> ENTER_B.
  - In ENTER_B with `digits`=0: replace `op_code` only.
  - In ENTER_B with `digits`>0 (chaining): `acc_a` = `acc_a` op `acc_b`, pulse `result_valid`, latch the new op, clear `acc_b`/`digits`, stay in ENTER_B.
  - In RESULT: `acc_a` keeps the result, latch op, state -> ENTER_B.
- **Equals:**
  - In ENTER_B: `acc_a` = `acc_a` op `acc_b` (`acc_b`=0 if no digits), pulse `result_valid`, state -> RESULT.
  - In ENTER_A: `result_valid` pulses with `acc_a` unchanged, state -> RESULT.
  - In RESULT: ignored.
- **Clear** (any state): all registers return to their reset values.
- **Arithmetic:**
  - Compute at 2*WIDTH signed precision, then truncate to WIDTH in two's complement.
  - `overflow` is set if the full result lies outside the signed WIDTH range.
  - `overflow` holds until clear or a new digit in RESULT. A later in-range computation does not clear it.
- **`display`:**
  - `acc_b` in ENTER_B when `digits`>0.
  - Otherwise `acc_a`.

## Timing
- **Reset values:** `display`=0, `op_code`=0, `state`=0, `result_valid`=0, `overflow`=0, `kp_q`=0, `acc_a`=`acc_b`=0, `digits`=0.
- **Latency:** all register and output updates become visible immediately after the event edge, which is 1 cycle from `key_pushed` rising at the input.
- **`result_valid`:** high for exactly one cycle, coincident with the new `display`.
- **Release and re-press:** `key_pushed` must be low for at least 1 cycle between presses. A press while `kp_q`=1 is not detected.
- **Reset mid-press:** after `rst_n` releases with `key_pushed` already high, the first edge counts as an event because `kp_q` was reset to 0.
- **Concurrent inputs:** the block has no other inputs that can collide with a key event. `rst_n` overrides everything asynchronously.

## Test plan
- **Basic entry:** keys 1, 8, A(+), 6, = -> `display` shows 1, 18, 18, 6, 24. `result_valid` pulses once. `state`=2.
- **Chaining and held keys:** keys 9, C(*), 9, B(-), 1, = with each key held 5 cycles -> `display` = 81 at `-`, final 80. Exactly two `result_valid` pulses, one per evaluation.
- **Digit limit:** keys 1, 2, 3, 4, 5 -> `display`=1234. The fifth digit is ignored and `digits` stays at 4.
- **Overflow (WIDTH=16):** keys 3, 0, 0, C, 2, 0, 0, = -> `overflow`=1, `display`=-5536. A following clear -> all outputs 0.
- **Result reuse:** after result 24, keys A, 1, = -> 25. A subsequent digit 7 -> `state`=0, `display`=7, `op_code`=0.
- **Reset and ignored codes:** asserting `rst_n`=0 mid-entry (after keys 5, A) -> outputs 0 immediately. An operator code of 4'hF is ignored, with no change to state.
